ps2_arrow_decoder: RTL and testbench

PS2_ARROW_DECODER -- requirements
Module: ps2_arrow_decoder

---
 rtl/ps2_arrow_decoder.sv | 171 +++++++++++++++++
 tb/tb_ps2_arrow_decoder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_arrow_decoder.sv
// PS/2 scan-code decoder turning arrow/keypad/WASD-style makes into per-player arrow events.
// Optional macro ARROW_REPEAT_SUPPRESS_EN drops typematic repeats until the key's break code.
module ps2_arrow_decoder #(
    parameter int unsigned PREFIX_TIMEOUT = 100000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    output logic       player1_key_pressed,
    output logic [7:0] player1_arrow_input,
    output logic       player2_key_pressed,
    output logic [7:0] player2_arrow_input,
    output logic       game_reset_req
);

    localparam int unsigned CNT_RAW  = $clog2(PREFIX_TIMEOUT + 1);
    localparam int unsigned CNT_W    = (CNT_RAW > 16) ? CNT_RAW : 16;
    localparam int unsigned KEY_W    = 4;
    localparam int unsigned NUM_KEYS = 9;
    localparam logic [KEY_W-1:0] NO_KEY   = KEY_W'(15);
    localparam logic [KEY_W-1:0] KEY_RST  = KEY_W'(8);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);
    localparam logic [7:0] BYTE_EXT = 8'he0;
    localparam logic [7:0] BYTE_BRK = 8'hf0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [KEY_W-1:0] key_idx;
    logic             ext_flag;
    logic             make_ev;
    logic             accept;
    logic             p1_pulse_d, p2_pulse_d, rst_req_d;
    logic [7:0]       p1_code_d, p2_code_d;
`ifdef ARROW_REPEAT_SUPPRESS_EN
    logic [NUM_KEYS-1:0] held, held_d;
`endif

    assign ext_flag = (state == EXT) || (state == EXT_BRK);

    // Key index 0-3: player 1 up/left/down/right, 4-7: player 2, 8: game reset
    always_comb begin
        key_idx = NO_KEY;
        if (!ext_flag) begin
            case (ps2_key_data)
                8'h1d:   key_idx = KEY_W'(0);
                8'h1c:   key_idx = KEY_W'(1);
                8'h1b:   key_idx = KEY_W'(2);
                8'h23:   key_idx = KEY_W'(3);
                8'h75:   key_idx = KEY_W'(4);
                8'h6b:   key_idx = KEY_W'(5);
                8'h72:   key_idx = KEY_W'(6);
                8'h74:   key_idx = KEY_W'(7);
                8'h2d:   key_idx = KEY_RST;
                default: key_idx = NO_KEY;
            endcase
        end else begin
            case (ps2_key_data)
                8'h75:   key_idx = KEY_W'(4);
                8'h6b:   key_idx = KEY_W'(5);
                8'h72:   key_idx = KEY_W'(6);
                8'h74:   key_idx = KEY_W'(7);
                default: key_idx = NO_KEY;
            endcase
        end
    end

    // Next-state, prefix timeout and event generation
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        make_ev    = 1'b0;
        accept     = 1'b0;
        p1_pulse_d = 1'b0;
        p2_pulse_d = 1'b0;
        rst_req_d  = 1'b0;
        p1_code_d  = player1_arrow_input;
        p2_code_d  = player2_arrow_input;
`ifdef ARROW_REPEAT_SUPPRESS_EN
        held_d     = held;
`endif

        if (ps2_key_pressed) begin
            cnt_d = '0;
            case (state)
                IDLE: begin
                    if (ps2_key_data == BYTE_EXT)      state_d = EXT;
                    else if (ps2_key_data == BYTE_BRK) state_d = BRK;
                    else                               make_ev = 1'b1;
                end
                EXT: begin
                    if (ps2_key_data == BYTE_BRK)      state_d = EXT_BRK;
                    else if (ps2_key_data == BYTE_EXT) state_d = EXT;
                    else begin
                        make_ev = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK, EXT_BRK: begin
                    state_d = IDLE;
`ifdef ARROW_REPEAT_SUPPRESS_EN
                    if (key_idx != NO_KEY) held_d[key_idx] = 1'b0;
`endif
                end
                default: state_d = IDLE;
            endcase
        end else if (state != IDLE) begin
            // A strobe on the expiry cycle takes the branch above instead
            if (cnt >= CNT_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt + CNT_W'(1);
            end
        end

`ifdef ARROW_REPEAT_SUPPRESS_EN
        accept = make_ev && (key_idx != NO_KEY) && !held[key_idx];
        if (accept) held_d[key_idx] = 1'b1;
`else
        accept = make_ev && (key_idx != NO_KEY);
`endif

        if (accept) begin
            if (key_idx < KEY_W'(4)) begin
                p1_pulse_d = 1'b1;
                p1_code_d  = 8'(key_idx) + 8'd1;
            end else if (key_idx < KEY_RST) begin
                p2_pulse_d = 1'b1;
                p2_code_d  = 8'(key_idx) - 8'd3;
            end else begin
                rst_req_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state               <= IDLE;
            cnt                 <= '0;
            player1_key_pressed <= 1'b0;
            player1_arrow_input <= 8'h00;
            player2_key_pressed <= 1'b0;
            player2_arrow_input <= 8'h00;
            game_reset_req      <= 1'b0;
        end else begin
            state               <= state_d;
            cnt                 <= cnt_d;
            player1_key_pressed <= p1_pulse_d;
            player1_arrow_input <= p1_code_d;
            player2_key_pressed <= p2_pulse_d;
            player2_arrow_input <= p2_code_d;
            game_reset_req      <= rst_req_d;
        end
    end

`ifdef ARROW_REPEAT_SUPPRESS_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) held <= '0;
        else         held <= held_d;
    end
`endif

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Randomized scoreboard bench for ps2_arrow_decoder against a prefix/held-key reference model.
module tb_ps2_arrow_decoder;

    localparam int unsigned P = 20;

    logic       clock;
    logic       resetn;
    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed;
    logic       player1_key_pressed;
    logic [7:0] player1_arrow_input;
    logic       player2_key_pressed;
    logic [7:0] player2_arrow_input;
    logic       game_reset_req;

    ps2_arrow_decoder #(.PREFIX_TIMEOUT(P)) dut (
        .clock               (clock),
        .resetn              (resetn),
        .ps2_key_data        (ps2_key_data),
        .ps2_key_pressed     (ps2_key_pressed),
        .player1_key_pressed (player1_key_pressed),
        .player1_arrow_input (player1_arrow_input),
        .player2_key_pressed (player2_key_pressed),
        .player2_arrow_input (player2_arrow_input),
        .game_reset_req      (game_reset_req)
    );

    typedef struct {
        int         kind;   // 1 = player 1, 2 = player 2, 3 = game reset
        logic [7:0] code;
        int         due;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   gap = 0;
    int   p2_seen = 0;
    bit   m_ext = 0;
    bit   m_brk = 0;
    bit   m_held[9];
    logic [7:0] mon_last1 = 8'h00;
    logic [7:0] mon_last2 = 8'h00;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference key table: -1 for keys that produce nothing
    function automatic int key_id(input logic [7:0] b, input bit ext);
        if (!ext) begin
            case (b)
                8'h1d: return 0;
                8'h1c: return 1;
                8'h1b: return 2;
                8'h23: return 3;
                8'h75: return 4;
                8'h6b: return 5;
                8'h72: return 6;
                8'h74: return 7;
                8'h2d: return 8;
                default: return -1;
            endcase
        end
        case (b)
            8'h75: return 4;
            8'h6b: return 5;
            8'h72: return 6;
            8'h74: return 7;
            default: return -1;
        endcase
    endfunction

    task automatic model_make(input logic [7:0] b, input bit ext);
        int   id;
        ev_t  e;
        logic [7:0] codes [9];
        codes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        id = key_id(b, ext);
        if (id < 0) return;
`ifdef ARROW_REPEAT_SUPPRESS_EN
        if (m_held[id]) return;
        m_held[id] = 1'b1;
`endif
        e.kind = (id < 4) ? 1 : ((id < 8) ? 2 : 3);
        e.code = codes[id];
        e.due  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic model_strobe(input logic [7:0] b);
        int id;
        if ((m_ext || m_brk) && gap >= int'(P)) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        gap = 0;
        if (m_brk) begin
            id = key_id(b, m_ext);
            if (id >= 0) m_held[id] = 1'b0;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'he0) begin
            m_ext = 1'b1;
        end else if (b == 8'hf0) begin
            m_brk = 1'b1;
        end else begin
            model_make(b, m_ext);
            m_ext = 1'b0;
        end
    endtask

    task automatic step(input logic s, input logic [7:0] d);
        @(posedge clock);
        #1;
        ps2_key_pressed = s;
        ps2_key_data    = d;
        if (s) model_strobe(d);
        else   gap++;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom_range(0, 255)));
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #1;
        ps2_key_pressed = 1'b0;
        resetn = 1'b0;
        #1;
        check("reset_outputs_immediate",
              {13'd0, player1_key_pressed, player1_arrow_input, player2_key_pressed,
               player2_arrow_input, game_reset_req}, 32'd0);
        m_ext = 1'b0;
        m_brk = 1'b0;
        gap   = 0;
        foreach (m_held[i]) m_held[i] = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    // Monitor: pops an expectation whenever the DUT presents an event
    always @(negedge clock) begin
        ev_t e;
        int  akind;
        logic [7:0] acode;
        if (!resetn) begin
            check("outputs_in_reset",
                  {13'd0, player1_key_pressed, player1_arrow_input, player2_key_pressed,
                   player2_arrow_input, game_reset_req}, 32'd0);
            mon_last1 = 8'h00;
            mon_last2 = 8'h00;
        end else begin
            if (player1_key_pressed && player2_key_pressed) begin
                failures++;
                $display("FAIL simultaneous_pulses at cycle %0d", cyc);
            end
            if (player2_key_pressed) p2_seen++;
            if (player1_key_pressed || player2_key_pressed || game_reset_req) begin
                akind = player1_key_pressed ? 1 : (player2_key_pressed ? 2 : 3);
                acode = player1_key_pressed ? player1_arrow_input :
                        (player2_key_pressed ? player2_arrow_input : 8'h00);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_event: got kind %0d code %0h, expected none (cycle %0d)",
                             akind, acode, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 32'(akind), 32'(e.kind));
                    check("event_code", 32'(acode), 32'(e.code));
                    check("event_latency_cycle", 32'(cyc), 32'(e.due));
                    if (e.kind == 1) mon_last1 = e.code;
                    if (e.kind == 2) mon_last2 = e.code;
                end
            end
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_event: got none, expected kind %0d code %0h due %0d",
                         e.kind, e.code, e.due);
            end
            check("p1_arrow_hold", 32'(player1_arrow_input), 32'(mon_last1));
            check("p2_arrow_hold", 32'(player2_arrow_input), 32'(mon_last2));
        end
    end

    initial begin
        int c0;
        int r;
        logic [7:0] pool [9];
        pool = '{8'h1d, 8'h1c, 8'h1b, 8'h23, 8'h75, 8'h6b, 8'h72, 8'h74, 8'h2d};
        foreach (m_held[i]) m_held[i] = 1'b0;
        resetn = 1'b1;
        ps2_key_pressed = 1'b0;
        ps2_key_data = 8'h00;
        #1 resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;

        // Basic player-1 make, then release it
        send(8'h1d); idle(2);
        send(8'hf0); send(8'h1d); idle(2);
        // Extended player-2 make and break, then a fresh make to confirm idle state
        send(8'he0); send(8'h74); idle(2);
        send(8'he0); send(8'hf0); send(8'h74); send(8'h1b); idle(2);
        // Extended versions of player-1 bytes are ignored
        send(8'he0); send(8'h1c); idle(2);
        // Typematic repeat behaviour
        c0 = p2_seen;
        send(8'h72); send(8'h72); send(8'h72); send(8'hf0); send(8'h72); send(8'h72); idle(3);
`ifdef ARROW_REPEAT_SUPPRESS_EN
        check("repeat_pulse_count", 32'(p2_seen - c0), 32'd2);
`else
        check("repeat_pulse_count", 32'(p2_seen - c0), 32'd4);
`endif
        send(8'hf0); send(8'h72); idle(2);
        // Prefix timeout: expired after P idle cycles, still alive after P-1
        send(8'hf0); idle(P); send(8'h23); idle(2);
        send(8'hf0); idle(P - 1); send(8'h23); idle(2);
        send(8'h23); idle(2);
        // Game reset key
        send(8'h2d); idle(2);
        send(8'hf0); send(8'h2d); send(8'h2d); idle(2);
        // Reset in the middle of a prefix
        send(8'he0); idle(2);
        pulse_reset();
        send(8'h75); idle(3);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            r = $urandom_range(0, 15);
            if (r < 9)       send(pool[r]);
            else if (r < 11) send(8'he0);
            else if (r < 13) send(8'hf0);
            else             send(8'($urandom_range(0, 255)));
            r = $urandom_range(0, 39);
            if (r < 24)      ;
            else if (r < 36) idle($urandom_range(1, 3));
            else if (r == 36) idle(P - 1);
            else if (r == 37) idle(P);
            else              idle(P + 2);
        end
        idle(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
